// File: rtl/codificador_pkg.sv
// Shared types and constants for the debounced, registered 4-to-2 encoder.
// The optional PRIORITY_ENC_EN build macro is honoured by codificador_4x2_core.
package codificador_pkg;

    // Controller states: wait for a key, debounce it, present the code, wait for release.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STABLE  = 2'd1,
        OUT     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Debounce counter width; wide enough for STABLE_CYCLES up to 15.
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    // One-hot request patterns and the index each one encodes to.
    localparam logic [3:0] ONEHOT_0 = 4'b0001;
    localparam logic [3:0] ONEHOT_1 = 4'b0010;
    localparam logic [3:0] ONEHOT_2 = 4'b0100;
    localparam logic [3:0] ONEHOT_3 = 4'b1000;

    localparam logic [1:0] IDX_0 = 2'd0;
    localparam logic [1:0] IDX_1 = 2'd1;
    localparam logic [1:0] IDX_2 = 2'd2;
    localparam logic [1:0] IDX_3 = 2'd3;

endpackage

// File: rtl/codificador_4x2_core.sv
// Purely combinational 4-to-2 encoder.
// Build macro PRIORITY_ENC_EN: when defined, any nonzero pattern encodes to its
// highest set index and is reported as encodable (onehot=1, multihot=0); when
// undefined, only one-hot patterns encode and multi-hot patterns raise multihot.
module codificador_4x2_core
    import codificador_pkg::*;
(
    input  logic [3:0] pattern,
    output logic [1:0] Y,
    output logic       onehot,
    output logic       multihot
);

    // Map the pattern to an index and classify it as encodable or rejected.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        Y        = IDX_0;
        onehot   = 1'b0;
        multihot = 1'b0;
`ifdef PRIORITY_ENC_EN
        onehot = |pattern;
        if (pattern[3]) begin
            Y = IDX_3;
        end else if (pattern[2]) begin
            Y = IDX_2;
        end else if (pattern[1]) begin
            Y = IDX_1;
        end else begin
            Y = IDX_0;
        end
`else
        case (pattern)
            ONEHOT_0: begin Y = IDX_0; onehot = 1'b1; end
            ONEHOT_1: begin Y = IDX_1; onehot = 1'b1; end
            ONEHOT_2: begin Y = IDX_2; onehot = 1'b1; end
            ONEHOT_3: begin Y = IDX_3; onehot = 1'b1; end
            default:  multihot = (pattern != 4'b0000);
        endcase
`endif
    end

endmodule

// File: rtl/codificador_4x2_reg.sv
// Debounced, registered 4-to-2 encoder with a valid/ready handshake.
// D is synchronised into d_q, must hold STABLE_CYCLES identical nonzero samples,
// is encoded once, held until accepted, and re-armed only after D returns to 0.
// Build macro PRIORITY_ENC_EN selects priority encoding of multi-hot patterns
// (otherwise they are rejected with a one-cycle err pulse).
module codificador_4x2_reg
    import codificador_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    input  logic       ready,
    output logic [1:0] Y,
    output logic       valid,
    output logic       err
);

    localparam cnt_t STABLE_CNT = cnt_t'(STABLE_CYCLES);

    logic [3:0] d_q;
    state_t     state_q, state_next;
    logic [3:0] snap_q, snap_next;
    cnt_t       cnt_q, cnt_next;
    logic [1:0] y_q, y_next;
    logic       valid_q, valid_next;
    logic       err_q, err_next;

    logic       eval;
    logic [3:0] eval_pat;
    logic [1:0] enc_y;
    logic       enc_onehot;
    logic       enc_multihot;

    // Register the raw request lines; every decision below looks only at d_q.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            d_q <= 4'b0000;
        end else begin
            d_q <= D;
        end
    end

    // In IDLE (STABLE_CYCLES=1) the fresh sample is evaluated; in STABLE d_q equals snap.
    assign eval_pat = (state_q == IDLE) ? d_q : snap_q;

    codificador_4x2_core u_core (
        .pattern  (eval_pat),
        .Y        (enc_y),
        .onehot   (enc_onehot),
        .multihot (enc_multihot)
    );

    // Next-state and next-output logic of the debounce/handshake controller.
    always_comb begin
        state_next = state_q;
        snap_next  = snap_q;
        cnt_next   = cnt_q;
        y_next     = y_q;
        valid_next = valid_q;
        err_next   = 1'b0;
        eval       = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_q != 4'b0000) begin
                    snap_next = d_q;
                    cnt_next  = cnt_t'(1);
                    if (STABLE_CYCLES == 1) begin
                        eval = 1'b1;
                    end else begin
                        state_next = STABLE;
                    end
                end
            end
            STABLE: begin
                if (d_q == 4'b0000) begin
                    state_next = IDLE;
                end else if (d_q == snap_q) begin
                    cnt_next = cnt_q + cnt_t'(1);
                    eval     = (cnt_next == STABLE_CNT);
                end else begin
                    // A different nonzero pattern restarts the debounce window.
                    snap_next = d_q;
                    cnt_next  = cnt_t'(1);
                end
            end
            OUT: begin
                // Being in OUT means valid was already high before this edge.
                if (ready) begin
                    valid_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (d_q == 4'b0000) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (eval) begin
            if (enc_onehot) begin
                y_next     = enc_y;
                valid_next = 1'b1;
                state_next = OUT;
            end else begin
                // Rejected pattern: flag it once, keep the previous code, wait for release.
                err_next   = enc_multihot;
                state_next = RELEASE;
            end
        end
    end

    // Controller and output registers; reset discards any pending code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= 4'b0000;
            cnt_q   <= '0;
            y_q     <= 2'b00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            snap_q  <= snap_next;
            cnt_q   <= cnt_next;
            y_q     <= y_next;
            valid_q <= valid_next;
            err_q   <= err_next;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
